// File: rtl/cpu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_seq_pkg
//  Description : Shared types and constants for the 65C02 interrupt/reset
//                entry sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DUMMY    = 3'd1,
        PUSH_PCH = 3'd2,
        PUSH_PCL = 3'd3,
        PUSH_P   = 3'd4,
        VEC_LO   = 3'd5,
        VEC_HI   = 3'd6,
        DONE     = 3'd7
    } seq_state_t;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_RESET = 2'd1,
        SRC_NMI   = 2'd2,
        SRC_IRQ   = 2'd3
    } int_src_t;

    typedef enum logic [1:0] {
        PSEL_PCH = 2'd0,
        PSEL_PCL = 2'd1,
        PSEL_P   = 2'd2
    } push_sel_t;

    // {push_vector, push_resb, push_nmib, push_irqb, reset_stack}
    localparam logic [4:0] VOPS_RESET = 5'b11000;
    localparam logic [4:0] VOPS_NMI   = 5'b10100;
    localparam logic [4:0] VOPS_IRQ   = 5'b10010;
    localparam logic [4:0] VOPS_STACK = 5'b00001;
    localparam logic [4:0] VOPS_NULL  = 5'b00000;

    function automatic logic [4:0] vops_for(input int_src_t src);
        logic [4:0] v;
        case (src)
            SRC_RESET: v = VOPS_RESET;
            SRC_NMI:   v = VOPS_NMI;
            SRC_IRQ:   v = VOPS_IRQ;
            default:   v = VOPS_NULL;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pin_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : pin_sync_edge
//  Description : Multi-flop synchronizer for an active-low CPU pin with
//                registered rise/fall strobes. Idles high out of reset.
//  Revision    : 1.0  initial release
// ============================================================================
module pin_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic sync_o,
    output logic fall_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   fall_q;
    logic                   rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            hist_q <= 1'b1;
            fall_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            hist_q <= sync_q[SYNC_STAGES-1];
            fall_q <= hist_q & ~sync_q[SYNC_STAGES-1];
            rise_q <= ~hist_q & sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign fall_o = fall_q;
    assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_sequencer
//  Description : Arbitrates RESB/NMIB/IRQB/BRK and sequences the 65C02 entry
//                (dummy, three pushes, vector fetch, done).
//  Revision    : 1.0  initial release
// ============================================================================
module interrupt_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] RESET_VEC   = 16'hFFFC,
    parameter logic [15:0] NMI_VEC     = 16'hFFFA,
    parameter logic [15:0] IRQ_VEC     = 16'hFFFE
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        resb,
    input  logic        nmib,
    input  logic        irqb,
    input  logic        i_flag,
    input  logic        rdy,
    input  logic        instr_boundary,
    input  logic        brk_req,
    output logic        seq_busy,
    output logic [2:0]  seq_step,
    output logic [1:0]  int_source,
    output logic        stack_write,
    output logic        sp_decrement,
    output logic [1:0]  push_sel,
    output logic        pushed_b,
    output logic        vpb,
    output logic [15:0] vector_addr,
    output logic [4:0]  vector_ops,
    output logic        set_i,
    output logic        clear_d,
    output logic        seq_done
);

    logic w_resb_sync;
    logic w_irqb_sync;
    logic w_nmib_fall;
    logic w_unused_resb_fall;
    logic w_unused_resb_rise;
    logic w_unused_nmib_sync;
    logic w_unused_nmib_rise;
    logic w_unused_irqb_fall;
    logic w_unused_irqb_rise;

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_resb_sync (
        .clk    (fclk),
        .rst    (rst),
        .pin_i  (resb),
        .sync_o (w_resb_sync),
        .fall_o (w_unused_resb_fall),
        .rise_o (w_unused_resb_rise)
    );

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nmib_sync (
        .clk    (fclk),
        .rst    (rst),
        .pin_i  (nmib),
        .sync_o (w_unused_nmib_sync),
        .fall_o (w_nmib_fall),
        .rise_o (w_unused_nmib_rise)
    );

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_irqb_sync (
        .clk    (fclk),
        .rst    (rst),
        .pin_i  (irqb),
        .sync_o (w_irqb_sync),
        .fall_o (w_unused_irqb_fall),
        .rise_o (w_unused_irqb_rise)
    );

    seq_state_t  state_q, state_d;
    int_src_t    src_q, src_d;
    logic        brk_q, brk_d;
    logic        nmi_pend_q, nmi_pend_d;
    logic        rst_pend_q, rst_pend_d;
    logic [15:0] w_vec_base;

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= SRC_NONE;
            brk_q      <= 1'b0;
            nmi_pend_q <= 1'b0;
            rst_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            brk_q      <= brk_d;
            nmi_pend_q <= nmi_pend_d;
            rst_pend_q <= rst_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        brk_d   = brk_q;
        if (!w_resb_sync) begin
            state_d = IDLE;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (rdy) begin
            case (state_q)
                IDLE: begin
                    // A released reset starts at once; everything else waits for a boundary.
                    if (rst_pend_q) begin
                        state_d = DUMMY;
                        src_d   = SRC_RESET;
                        brk_d   = 1'b0;
                    end else if (instr_boundary) begin
                        if (nmi_pend_q) begin
                            state_d = DUMMY;
                            src_d   = SRC_NMI;
                            brk_d   = 1'b0;
                        end else if (brk_req) begin
                            state_d = DUMMY;
                            src_d   = SRC_IRQ;
                            brk_d   = 1'b1;
                        end else if (!w_irqb_sync && !i_flag) begin
                            state_d = DUMMY;
                            src_d   = SRC_IRQ;
                            brk_d   = 1'b0;
                        end
                    end
                end
                DUMMY:    state_d = PUSH_PCH;
                PUSH_PCH: state_d = PUSH_PCL;
                PUSH_PCL: state_d = PUSH_P;
                PUSH_P:   state_d = VEC_LO;
                VEC_LO:   state_d = VEC_HI;
                VEC_HI:   state_d = DONE;
                default:  state_d = IDLE;
            endcase
        end

        // Set terms are ORed last so a fresh request beats a same-cycle clear.
        nmi_pend_d = (nmi_pend_q & ~((state_q == DUMMY) && (state_d == PUSH_PCH)
                                     && (src_q == SRC_NMI))) | w_nmib_fall;
        rst_pend_d = (rst_pend_q & ~((state_q == IDLE) && (state_d == DUMMY)))
                     | ~w_resb_sync;
    end

    assign w_vec_base = (src_q == SRC_RESET) ? RESET_VEC :
                        (src_q == SRC_NMI)   ? NMI_VEC   : IRQ_VEC;

    always_comb begin
        seq_busy     = 1'b0;
        seq_step     = IDLE;
        int_source   = SRC_NONE;
        stack_write  = 1'b0;
        sp_decrement = 1'b0;
        push_sel     = PSEL_PCH;
        pushed_b     = 1'b0;
        vpb          = 1'b1;
        vector_addr  = 16'h0000;
        vector_ops   = VOPS_NULL;
        set_i        = 1'b0;
        clear_d      = 1'b0;
        seq_done     = 1'b0;
        // While resb is held low the step outputs are silenced, even for the
        // cycle the state register still shows the aborted step.
        if (w_resb_sync) begin
            seq_busy = (state_q != IDLE);
            seq_step = state_q;
            if (state_q != IDLE) begin
                int_source = src_q;
            end
            case (state_q)
                DUMMY: begin
                    if (src_q == SRC_RESET) begin
                        vector_ops = VOPS_STACK;
                    end
                end
                PUSH_PCH, PUSH_PCL, PUSH_P: begin
                    sp_decrement = 1'b1;
                    stack_write  = (src_q != SRC_RESET);
                    push_sel     = (state_q == PUSH_PCH) ? PSEL_PCH :
                                   (state_q == PUSH_PCL) ? PSEL_PCL : PSEL_P;
                    pushed_b     = (state_q == PUSH_P) && brk_q;
                end
                VEC_LO, VEC_HI: begin
                    vpb         = 1'b0;
                    vector_ops  = vops_for(src_q);
                    vector_addr = (state_q == VEC_HI) ? (w_vec_base + 16'd1) : w_vec_base;
                end
                DONE: begin
                    set_i    = 1'b1;
                    clear_d  = 1'b1;
                    seq_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_sequencer
//  Description : Self-checking bench for interrupt_sequencer; expected step
//                outputs come from a rule-based model of the entry sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_interrupt_sequencer;

    localparam int SYNC = 2;

    logic        fclk = 1'b0;
    logic        rst, resb, nmib, irqb, i_flag, rdy, instr_boundary, brk_req;
    logic        seq_busy, stack_write, sp_decrement, pushed_b, vpb;
    logic        set_i, clear_d, seq_done;
    logic [2:0]  seq_step;
    logic [1:0]  int_source, push_sel;
    logic [15:0] vector_addr;
    logic [4:0]  vector_ops;

    int checks = 0;
    int errors = 0;

    interrupt_sequencer #(.SYNC_STAGES(SYNC)) dut (
        .fclk           (fclk),
        .rst            (rst),
        .resb           (resb),
        .nmib           (nmib),
        .irqb           (irqb),
        .i_flag         (i_flag),
        .rdy            (rdy),
        .instr_boundary (instr_boundary),
        .brk_req        (brk_req),
        .seq_busy       (seq_busy),
        .seq_step       (seq_step),
        .int_source     (int_source),
        .stack_write    (stack_write),
        .sp_decrement   (sp_decrement),
        .push_sel       (push_sel),
        .pushed_b       (pushed_b),
        .vpb            (vpb),
        .vector_addr    (vector_addr),
        .vector_ops     (vector_ops),
        .set_i          (set_i),
        .clear_d        (clear_d),
        .seq_done       (seq_done)
    );

    always #5 fclk = ~fclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [35:0] dut_out();
        return {seq_busy, seq_step, int_source, stack_write, sp_decrement, push_sel,
                pushed_b, vpb, vector_addr, vector_ops, set_i, clear_d, seq_done};
    endfunction

    // Expected outputs at step k (0 = idle, 1..7 = dummy..done) for source
    // src (1 reset, 2 NMI, 3 IRQ/BRK).
    function automatic logic [35:0] exp_out(input int src, input bit brk, input int k);
        bit          push, vec;
        logic [15:0] base, addr;
        logic [4:0]  vops;
        push = (k >= 2) && (k <= 4);
        vec  = (k == 5) || (k == 6);
        base = (src == 1) ? 16'hFFFC : (src == 2) ? 16'hFFFA : 16'hFFFE;
        addr = vec ? base + 16'(k - 5) : 16'h0000;
        vops = 5'b00000;
        if (k == 1 && src == 1) vops = 5'b00001;
        if (vec) vops = 5'b10000 | (5'b10000 >> src);
        return {k != 0, 3'(k), (k != 0) ? 2'(src) : 2'd0, push && (src != 1), push,
                push ? 2'(k - 2) : 2'd0, (k == 4) && brk, !vec, addr, vops,
                k == 7, k == 7, k == 7};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge fclk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        checks++;
        if (dut_out() !== exp_out(0, 0, 0)) begin
            errors++;
            $display("FAIL reset_state got %h want %h", dut_out(), exp_out(0, 0, 0));
        end
        rst = 1'b0;
        cyc(2);
        resb = 1'b0;
        cyc(5);
        checks++;
        if (dut_out() !== exp_out(0, 0, 0)) begin
            errors++;
            $display("FAIL resb_low_idle got %h want %h", dut_out(), exp_out(0, 0, 0));
        end
        resb = 1'b1;
        cyc(SYNC);
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            checks++;
            if (dut_out() !== exp_out(1, 0, k % 8)) begin
                errors++;
                $display("FAIL reset_seq k=%0d got %h want %h", k, dut_out(), exp_out(1, 0, k % 8));
            end
        end
    endtask

    task automatic test_irq();
        i_flag = 1'b0;
        irqb   = 1'b0;
        cyc(SYNC + 1);
        instr_boundary = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            checks++;
            if (dut_out() !== exp_out(3, 0, k % 8)) begin
                errors++;
                $display("FAIL irq_seq k=%0d got %h want %h", k, dut_out(), exp_out(3, 0, k % 8));
            end
            if (k == 1) begin
                instr_boundary = 1'b0;
                irqb = 1'b1;
            end
        end
        cyc(SYNC + 1);
    endtask

    task automatic test_irq_masked();
        i_flag = 1'b1;
        irqb   = 1'b0;
        cyc(SYNC + 1);
        for (int b = 0; b < 3; b++) begin
            instr_boundary = 1'b1;
            cyc(1);
            instr_boundary = 1'b0;
            cyc($urandom_range(1, 3));
            checks++;
            if (seq_busy !== 1'b0) begin
                errors++;
                $display("FAIL irq_masked boundary=%0d busy got %b want 0", b, seq_busy);
            end
        end
        irqb = 1'b1;
        cyc(SYNC + 1);
    endtask

    task automatic test_nmi_irq();
        i_flag = 1'b0;
        irqb   = 1'b0;
        nmib   = 1'b0;
        cyc($urandom_range(2, 4));
        nmib = 1'b1;
        cyc(3);
        for (int pass = 0; pass < 2; pass++) begin
            instr_boundary = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                cyc(1);
                checks++;
                if (dut_out() !== exp_out(pass == 0 ? 2 : 3, 0, k % 8)) begin
                    errors++;
                    $display("FAIL nmi_then_irq pass=%0d k=%0d got %h want %h", pass, k,
                             dut_out(), exp_out(pass == 0 ? 2 : 3, 0, k % 8));
                end
                if (k == 1) instr_boundary = 1'b0;
                if (k == 1 && pass == 1) irqb = 1'b1;
            end
        end
        cyc(SYNC + 1);
    endtask

    task automatic test_brk_irq();
        i_flag = 1'b0;
        irqb   = 1'b0;
        cyc(SYNC + 1);
        brk_req = 1'b1;
        instr_boundary = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            checks++;
            if (dut_out() !== exp_out(3, 1, k % 8)) begin
                errors++;
                $display("FAIL brk_seq k=%0d got %h want %h", k, dut_out(), exp_out(3, 1, k % 8));
            end
            if (k == 1) begin
                instr_boundary = 1'b0;
                brk_req = 1'b0;
                irqb = 1'b1;
            end
        end
        cyc(SYNC + 1);
    endtask

    task automatic test_rdy_stall();
        i_flag = 1'b0;
        irqb   = 1'b0;
        cyc(SYNC + 1);
        instr_boundary = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            checks++;
            if (dut_out() !== exp_out(3, 0, k % 8)) begin
                errors++;
                $display("FAIL rdy_stall k=%0d got %h want %h", k, dut_out(), exp_out(3, 0, k % 8));
            end
            if (k == 1) begin
                instr_boundary = 1'b0;
                irqb = 1'b1;
            end
            if (k == 3) begin
                rdy = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    cyc(1);
                    checks++;
                    if (dut_out() !== exp_out(3, 0, 3)) begin
                        errors++;
                        $display("FAIL rdy_hold s=%0d got %h want %h", s, dut_out(), exp_out(3, 0, 3));
                    end
                end
                rdy = 1'b1;
            end
        end
        cyc(SYNC + 1);
    endtask

    task automatic test_reset_midseq();
        bit saw_done;
        int waited;
        saw_done = 1'b0;
        waited   = 0;
        i_flag = 1'b0;
        irqb   = 1'b0;
        cyc(SYNC + 1);
        instr_boundary = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            checks++;
            if (dut_out() !== exp_out(3, 0, k)) begin
                errors++;
                $display("FAIL abort_prefix k=%0d got %h want %h", k, dut_out(), exp_out(3, 0, k));
            end
            if (k == 1) begin
                instr_boundary = 1'b0;
                irqb = 1'b1;
            end
        end
        resb = 1'b0;
        while (seq_busy === 1'b1 && waited < SYNC + 1) begin
            cyc(1);
            waited++;
            if (seq_done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (seq_busy !== 1'b0 || seq_step !== 3'd0 || saw_done) begin
            errors++;
            $display("FAIL reset_abort busy=%b step=%0d done_seen=%0d after %0d cycles want idle",
                     seq_busy, seq_step, saw_done, waited);
        end
        cyc(3);
        checks++;
        if (dut_out() !== exp_out(0, 0, 0)) begin
            errors++;
            $display("FAIL abort_hold got %h want %h", dut_out(), exp_out(0, 0, 0));
        end
        resb = 1'b1;
        cyc(SYNC);
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            checks++;
            if (dut_out() !== exp_out(1, 0, k % 8)) begin
                errors++;
                $display("FAIL abort_reset_seq k=%0d got %h want %h", k, dut_out(), exp_out(1, 0, k % 8));
            end
        end
    endtask

    task automatic test_nmi_renmi();
        nmib = 1'b0;
        cyc(2);
        nmib = 1'b1;
        cyc(3);
        for (int pass = 0; pass < 2; pass++) begin
            instr_boundary = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                cyc(1);
                checks++;
                if (dut_out() !== exp_out(2, 0, k % 8)) begin
                    errors++;
                    $display("FAIL renmi pass=%0d k=%0d got %h want %h", pass, k,
                             dut_out(), exp_out(2, 0, k % 8));
                end
                if (k == 1) instr_boundary = 1'b0;
                if (k == 6 && pass == 0) nmib = 1'b0;
            end
            nmib = 1'b1;
            cyc(3);
        end
    endtask

    task automatic test_random_arbitration();
        for (int it = 0; it < 24; it++) begin
            bit nmi_e, brk, irq, iflag, ebrk;
            int esrc, stall_k, stall_n;
            nmi_e   = ($urandom_range(0, 3) == 0);
            brk     = ($urandom_range(0, 2) == 0);
            irq     = $urandom_range(0, 1);
            iflag   = $urandom_range(0, 1);
            stall_k = $urandom_range(1, 6);
            stall_n = $urandom_range(0, 3);
            // Reference arbitration: NMI, then BRK, then unmasked IRQ.
            ebrk = 1'b0;
            if (nmi_e)              esrc = 2;
            else if (brk)           begin esrc = 3; ebrk = 1'b1; end
            else if (irq && !iflag) esrc = 3;
            else                    esrc = 0;

            irqb   = !irq;
            i_flag = iflag;
            if (nmi_e) nmib = 1'b0;
            cyc(2);
            nmib = 1'b1;
            cyc($urandom_range(3, 5));
            brk_req = brk;
            instr_boundary = 1'b1;
            if (esrc == 0) begin
                cyc(1);
                instr_boundary = 1'b0;
                brk_req = 1'b0;
                cyc(1);
                checks++;
                if (dut_out() !== exp_out(0, 0, 0)) begin
                    errors++;
                    $display("FAIL rand_none it=%0d got %h want %h", it, dut_out(), exp_out(0, 0, 0));
                end
            end else begin
                for (int k = 1; k <= 8; k++) begin
                    cyc(1);
                    checks++;
                    if (dut_out() !== exp_out(esrc, ebrk, k % 8)) begin
                        errors++;
                        $display("FAIL rand_seq it=%0d k=%0d got %h want %h", it, k,
                                 dut_out(), exp_out(esrc, ebrk, k % 8));
                    end
                    if (k == 1) begin
                        instr_boundary = 1'b0;
                        brk_req = 1'b0;
                        irqb = 1'b1;
                    end
                    if (k == stall_k && stall_n > 0) begin
                        rdy = 1'b0;
                        for (int s = 0; s < stall_n; s++) begin
                            cyc(1);
                            checks++;
                            if (dut_out() !== exp_out(esrc, ebrk, k)) begin
                                errors++;
                                $display("FAIL rand_stall it=%0d k=%0d got %h want %h", it, k,
                                         dut_out(), exp_out(esrc, ebrk, k));
                            end
                        end
                        rdy = 1'b1;
                    end
                end
            end
            irqb = 1'b1;
            cyc(SYNC + 2);
        end
    endtask

    initial begin
        rst            = 1'b1;
        resb           = 1'b1;
        nmib           = 1'b1;
        irqb           = 1'b1;
        i_flag         = 1'b1;
        rdy            = 1'b1;
        instr_boundary = 1'b0;
        brk_req        = 1'b0;

        test_reset();
        test_irq();
        test_irq_masked();
        test_nmi_irq();
        test_brk_irq();
        test_rdy_stall();
        test_reset_midseq();
        test_nmi_renmi();
        test_random_arbitration();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
